oledrgb_spi_streamer: RTL

Parametrised SPI command/data streamer for the Pmod OLEDrgb (SSD1331) path, successor to the fixed 15-register command sender. Software or a PL master pushes bytes, each tagged with a D/C flag, into an internal FIFO. One start then streams the FIFO contents out over SPI with chip-select framing. Bytes written during a transfer join the same frame, so long pixel bursts need no re-arming.

---
 rtl/oledrgb_spi_streamer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/oledrgb_spi_streamer.sv
// SPI command/data streamer for the SSD1331 (Pmod OLEDrgb): a tagged-byte FIFO drained over SPI
// inside one chip-select frame per start. Bytes written while a frame runs extend that frame.
// Latency: a sampled start drives cs low, pops the head and presents MSB + D/C on the next edge.
// Backpressure: o_full / o_count; writes while full are dropped; i_abort flushes everything.
//
// Ports:
//   i_clk, i_n_reset           clock, synchronous active-low reset
//   i_wr_en/i_wr_dc/i_wr_data  FIFO push of {D/C tag, byte}
//   o_full, o_count            FIFO occupancy
//   i_start, i_abort           frame start (level or pulse), frame kill + FIFO flush
//   o_busy, o_done             frame in progress, one-cycle end-of-frame pulse
//   o_cs_n, o_sclk, o_mosi, o_dc  SPI pins plus the D/C line for the byte on the wire
module oledrgb_spi_streamer #(
  parameter int DEPTH   = 16,
  parameter int CLK_DIV = 4,
  parameter bit CPOL    = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_n_reset,
  input  logic                     i_wr_en,
  input  logic                     i_wr_dc,
  input  logic [7:0]               i_wr_data,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count,
  input  logic                     i_start,
  input  logic                     i_abort,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_cs_n,
  output logic                     o_sclk,
  output logic                     o_mosi,
  output logic                     o_dc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Divider counter needs at least one bit even when CLK_DIV == 1.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [8:0]    head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // ---------------------------------------------------------------- FSM state
  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic          half;      // 0: first half of a bit (sclk active), 1: second half (sclk idle)
  logic [7:0]    shreg;
  logic          cs_n;
  logic          sclk;
  logic          mosi;
  logic          dc;
  logic          busy;
  logic          done;
  logic          div_end;
  logic          last_edge;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign div_end = (div_cnt == DIV_LAST);

  // Cycle in which bit 0's second half ends: the chaining decision point.
  assign last_edge = (state == SHIFT) && half && div_end && (bit_cnt == 3'd7);

  // Abort outranks both the write port and any pop.
  assign push = i_wr_en && !full && !i_abort;
  assign pop  = !i_abort && !empty && (((state == IDLE) && i_start) || last_edge);

  always_ff @(posedge i_clk) begin
    if (i_n_reset && push) begin
      mem[wr_ptr] <= {i_wr_dc, i_wr_data};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_n_reset || i_abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk) begin
    if (!i_n_reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      half    <= 1'b0;
      shreg   <= '0;
      cs_n    <= 1'b1;
      sclk    <= CPOL;
      mosi    <= 1'b0;
      dc      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (i_abort) begin
        state   <= IDLE;
        div_cnt <= '0;
        bit_cnt <= '0;
        half    <= 1'b0;
        cs_n    <= 1'b1;
        sclk    <= CPOL;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (pop) begin
              shreg   <= head[7:0];
              dc      <= head[8];
              mosi    <= head[7];
              cs_n    <= 1'b0;
              busy    <= 1'b1;
              div_cnt <= '0;
              state   <= SETUP;
            end
          end

          // SCLK held idle so D/C and the first data bit settle before the first edge.
          SETUP: begin
            if (div_end) begin
              div_cnt <= '0;
              bit_cnt <= '0;
              half    <= 1'b0;
              sclk    <= ~CPOL;
              state   <= SHIFT;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end

          SHIFT: begin
            if (!div_end) begin
              div_cnt <= div_cnt + 1'b1;
            end else begin
              div_cnt <= '0;
              if (!half) begin
                // Mid-bit edge back to idle: the slave samples here.
                sclk <= CPOL;
                half <= 1'b1;
              end else if (bit_cnt != 3'd7) begin
                // Start of the next bit: data changes together with the leading edge.
                shreg   <= {shreg[6:0], 1'b0};
                mosi    <= shreg[6];
                sclk    <= ~CPOL;
                half    <= 1'b0;
                bit_cnt <= bit_cnt + 3'd1;
              end else if (pop) begin
                // More bytes queued: stay in the frame, reload during idle SCLK.
                shreg <= head[7:0];
                dc    <= head[8];
                mosi  <= head[7];
                state <= SETUP;
              end else begin
                state <= HOLD;
              end
            end
          end

          HOLD: begin
            if (div_end) begin
              div_cnt <= '0;
              cs_n    <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= IDLE;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign o_full  = full;
  assign o_count = count;
  assign o_busy  = busy;
  assign o_done  = done;
  assign o_cs_n  = cs_n;
  assign o_sclk  = sclk;
  assign o_mosi  = mosi;
  assign o_dc    = dc;

endmodule
